// File: rtl/wrr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter (wrr_arb).
package wrr_arb_pkg;

  // Upper bound on requester count supported by the helper functions.
  localparam int WRR_MAX_N  = 64;
  localparam int WRR_MAX_IW = 6;

  // Arbiter FSM: IDLE holds no grant, BUSY holds exactly one grant.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Rotate an n-bit one-hot vector up by one position, wrapping bit n-1 to bit 0.
  function automatic logic [WRR_MAX_N-1:0] rot1_onehot(input logic [WRR_MAX_N-1:0] v,
                                                       input int n);
    logic [WRR_MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < WRR_MAX_N; i++) begin
      if (i < n && v[i]) r[(i + 1) % n] = 1'b1;
    end
    return r;
  endfunction

  // Binary index of the set bit of a one-hot vector (zero for an all-zero vector).
  function automatic logic [WRR_MAX_IW-1:0] onehot_to_idx(input logic [WRR_MAX_N-1:0] v);
    logic [WRR_MAX_IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < WRR_MAX_N; i++) begin
      if (v[i]) idx = idx | WRR_MAX_IW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wrr_arb_rr_pick.sv
// rr_pick: combinational wrap-around priority picker. Returns the first set
// req bit at or above the one-hot pointer, wrapping from bit N-1 to bit 0.
module rr_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] ptr,
  output logic [N-1:0] win
);

  logic [2*N-1:0] dbl_req;
  logic [2*N-1:0] mask;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Duplicate req so a single lowest-set-bit search covers the wrap; the mask
  // keeps only positions at or above the pointer in the doubled vector.
  always_comb begin
    dbl_req = {req, req};
    mask    = ~({{N{1'b0}}, ptr} - (2*N)'(1));
    masked  = dbl_req & mask;
    first   = masked & (~masked + (2*N)'(1));
    win     = first[N-1:0] | first[2*N-1:N];
  end

endmodule

// File: rtl/wrr_arb.sv
// wrr_arb: weighted round-robin arbiter with registered one-hot grant.
// Handshake: gnt_vld is the valid side, ack is the ready side; a grant is
// consumed on a cycle where gnt_vld && ack. Each consumed grant spends one
// credit; when credit runs out (or the holder drops req) the pointer moves one
// past the holder and the same edge re-arbitrates.
// Optional feature: define WRR_ARB_LOCK_EN to add the lock input, which pins
// the current grant (no credit spend) while lock[gnt_idx] is high.
module wrr_arb
  import wrr_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int WW = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  init_pri,
  input  logic [N*WW-1:0] weight,
  input  logic [N-1:0]  req,
  input  logic          ack,
`ifdef WRR_ARB_LOCK_EN
  input  logic [N-1:0]  lock,
`endif
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld,
  output state_e        dbg_state
);

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [WW-1:0] credit_q, credit_d;

  logic [N-1:0]  ptr_rot;
  logic [N-1:0]  pick_ptr;
  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic [WW-1:0] win_wt;
  logic [WW-1:0] load_credit;
  logic          cur_req;
  logic          locked;
  logic [N-1:0]  rst_ptr;

  // In BUSY the only arbitration that matters is the release re-arbitration,
  // which always uses the pointer one past the holder; IDLE uses the stored pointer.
  always_comb begin
    ptr_rot     = N'(rot1_onehot(WRR_MAX_N'(gnt_q), N));
    pick_ptr    = (state_q == ST_BUSY) ? ptr_rot : ptr_q;
    win_idx     = IW'(onehot_to_idx(WRR_MAX_N'(win)));
    win_wt      = weight[win_idx*WW +: WW];
    load_credit = (win_wt == '0) ? WW'(1) : win_wt;
    cur_req     = |(req & gnt_q);
    rst_ptr     = $onehot(init_pri) ? init_pri : N'(1);
  end

`ifdef WRR_ARB_LOCK_EN
  assign locked = |(lock & gnt_q);
`else
  assign locked = 1'b0;
`endif

  rr_pick #(.N(N)) u_rr_pick (
    .req (req),
    .ptr (pick_ptr),
    .win (win)
  );

  // Next-state, grant, credit and pointer decisions.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          gnt_d    = win;
          credit_d = load_credit;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (ack) begin
          if (locked && cur_req) begin
            // Pinned: hold grant, keep credit untouched.
          end else if (credit_q > WW'(1) && cur_req) begin
            credit_d = credit_q - WW'(1);
          end else begin
            ptr_d = ptr_rot;
            if (|req) begin
              gnt_d    = win;
              credit_d = load_credit;
            end else begin
              gnt_d    = '0;
              credit_d = '0;
              state_d  = ST_IDLE;
            end
          end
        end else if (!cur_req) begin
          gnt_d    = '0;
          credit_d = '0;
          ptr_d    = ptr_rot;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        credit_d = '0;
      end
    endcase
  end

  // State registers; pointer reloads from init_pri while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      credit_q <= '0;
      ptr_q    <= rst_ptr;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      credit_q <= credit_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_vld   = |gnt_q;
  assign gnt_idx   = IW'(onehot_to_idx(WRR_MAX_N'(gnt_q)));
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wrr_arb.sv
// Directed bench for wrr_arb with N=4, WW=4.
module tb_wrr_arb;
  import wrr_arb_pkg::*;

  localparam int N  = 4;
  localparam int WW = 4;
  localparam int IW = 2;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  init_pri;
  logic [N*WW-1:0] weight;
  logic [N-1:0]  req;
  logic          ack;
`ifdef WRR_ARB_LOCK_EN
  logic [N-1:0]  lock;
`endif
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_vld;
  state_e        dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];

  wrr_arb #(.N(N), .WW(WW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_pri  (init_pri),
    .weight    (weight),
    .req       (req),
    .ack       (ack),
`ifdef WRR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld),
    .dbg_state (dbg_state)
  );

  // Clock and reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [N-1:0] ip);
    init_pri = ip;
    req      = '0;
    ack      = 1'b0;
    #1;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
  endtask

  task automatic chk_gnt(input string tag, input logic [N-1:0] e, input logic [IW-1:0] ei);
    chk({tag, "_gnt"}, 32'(gnt), 32'(e));
    chk({tag, "_vld"}, 32'(gnt_vld), 32'(|e));
    if (|e) chk({tag, "_idx"}, 32'(gnt_idx), 32'(ei));
  endtask

  initial begin
    rst_n    = 1'b0;
    init_pri = 4'b0001;
    weight   = 16'h1111;
    req      = '0;
    ack      = 1'b0;
`ifdef WRR_ARB_LOCK_EN
    lock     = '0;
`endif
    #1;
    // Reset state.
    chk("rst_gnt",    32'(gnt), 32'h0);
    chk("rst_idx",    32'(gnt_idx), 32'h0);
    chk("rst_vld",    32'(gnt_vld), 32'h0);
    chk("rst_state",  32'(dbg_state), 32'(ST_IDLE));
    chk("rst_credit", 32'(dut.credit_q), 32'h0);
    step();
    rst_n = 1'b1;

    // ack while idle is ignored.
    ack = 1'b1;
    step();
    chk("idle_ack_gnt",   32'(gnt), 32'h0);
    chk("idle_ack_state", 32'(dbg_state), 32'(ST_IDLE));

    // Plain round robin, all weights 1, ack every cycle.
    do_reset(4'b0001);
    weight = 16'h1111;
    req    = 4'b1111;
    ack    = 1'b1;
    exp_q  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    while (exp_q.size() > 0) begin
      logic [N-1:0] e;
      e = exp_q.pop_front();
      step();
      chk("rr_gnt", 32'(gnt), 32'(e));
      chk("rr_vld", 32'(gnt_vld), 32'h1);
    end

    // Weighted: requester 0 weight 3, req=0011.
    do_reset(4'b0001);
    weight = 16'h1113;
    req    = 4'b0011;
    ack    = 1'b1;
    step(); chk_gnt("w1", 4'b0001, 2'd0); chk("w1_credit", 32'(dut.credit_q), 32'd3);
    step(); chk_gnt("w2", 4'b0001, 2'd0); chk("w2_credit", 32'(dut.credit_q), 32'd2);
    step(); chk_gnt("w3", 4'b0001, 2'd0);
    step(); chk_gnt("w4", 4'b0010, 2'd1);
    step(); chk_gnt("w5", 4'b0001, 2'd0); chk("w5_credit", 32'(dut.credit_q), 32'd3);
    // Weight change while busy affects only the next load.
    weight = 16'h1112;
    step(); chk_gnt("wc6", 4'b0001, 2'd0); chk("wc6_credit", 32'(dut.credit_q), 32'd2);
    step(); chk_gnt("wc7", 4'b0001, 2'd0);
    step(); chk_gnt("wc8", 4'b0010, 2'd1);
    step(); chk_gnt("wc9", 4'b0001, 2'd0); chk("wc9_credit", 32'(dut.credit_q), 32'd2);

    // Holder drops req without ack.
    do_reset(4'b0100);
    weight = 16'h1111;
    req    = 4'b0100;
    ack    = 1'b0;
    step(); chk_gnt("drop_hold", 4'b0100, 2'd2);
    req = 4'b1001;
    step(); chk_gnt("drop_clr", 4'b0000, 2'd0);
    chk("drop_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("drop_ptr", 32'(dut.ptr_q), 32'h8);
    step(); chk_gnt("drop_next", 4'b1000, 2'd3);

    // Zero weight, single requester: regranted every ack, credit reloads to 1.
    do_reset(4'b0001);
    weight = 16'h1101;
    req    = 4'b0010;
    ack    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_gnt("zw", 4'b0010, 2'd1);
      chk("zw_credit", 32'(dut.credit_q), 32'd1);
    end

    // Mid-grant asynchronous reset with init_pri=0100.
    do_reset(4'b0100);
    weight = 16'h1111;
    req    = 4'b1111;
    ack    = 1'b0;
    step(); chk_gnt("ar_first", 4'b0100, 2'd2);
    step(); chk_gnt("ar_stable", 4'b0100, 2'd2);
    ack = 1'b1;
    step(); chk_gnt("ar_rot", 4'b1000, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_async_gnt", 32'(gnt), 32'h0);
    chk("ar_async_vld", 32'(gnt_vld), 32'h0);
    chk("ar_async_ptr", 32'(dut.ptr_q), 32'h4);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack   = 1'b0;
    step(); chk_gnt("ar_post", 4'b0100, 2'd2);

    // Non-one-hot init_pri falls back to bit 0.
    do_reset(4'b0110);
    chk("noh_ptr", 32'(dut.ptr_q), 32'h1);
    req = 4'b1111;
    step(); chk_gnt("noh_gnt", 4'b0001, 2'd0);

`ifdef WRR_ARB_LOCK_EN
    // Lock pins the grant for three acks, release on the first unlocked ack.
    do_reset(4'b0001);
    weight = 16'h1111;
    req    = 4'b0011;
    lock   = 4'b0001;
    ack    = 1'b1;
    step(); chk_gnt("lk0", 4'b0001, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_gnt("lk_hold", 4'b0001, 2'd0);
      chk("lk_credit", 32'(dut.credit_q), 32'd1);
    end
    lock = 4'b0000;
    step(); chk_gnt("lk_rel", 4'b0010, 2'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
